// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core-side request/response and word-wide memory bus of the load/store unit.
// slave is the controller's view, master is the view of whoever drives the core and memory side.
interface lsu_ctrl_if #(parameter int ADDR_W = 32);
  logic              lsu_reqValid;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic [1:0]        lsu_size;
  logic              lsu_unsigned;
  logic              lsu_respValid;
  logic [31:0]       lsu_rdata;
  logic              lsu_err;
  logic              mem_reqValid;
  logic              mem_reqReady;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_respValid;
  logic [31:0]       mem_rdata;
  modport slave (
    input  lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned,
           mem_reqReady, mem_respValid, mem_rdata,
    output lsu_respValid, lsu_rdata, lsu_err,
           mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned,
           mem_reqReady, mem_respValid, mem_rdata,
    input  lsu_respValid, lsu_rdata, lsu_err,
           mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word load-store controller bridging a core to a word-wide memory bus.
// Define LSU_MISALIGN_CHECK_EN to turn misaligned half/word accesses into one-cycle error responses.
module lsu_ctrl #(parameter int ADDR_W = 32) (
  input logic        clock,
  input logic        reset,
  lsu_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q, rdata_ext;
  logic [1:0] size_q;
  logic uns_q, wen_q, err_q, misalign;
  logic [7:0] rd_b;
  logic [15:0] rd_h;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (bus.lsu_size == 2'd1 && bus.lsu_addr[0]) || (bus.lsu_size[1] && bus.lsu_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.lsu_reqValid ? (misalign ? RESP : REQ) : IDLE) :
               state == REQ  ? (bus.mem_reqReady ? WAIT : REQ) :
               state == WAIT ? (bus.mem_respValid ? RESP : WAIT) : IDLE;
  assign rd_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign rd_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign rdata_ext = size_q == 2'd0 ? {{24{!uns_q && rd_b[7]}}, rd_b} :
                     size_q == 2'd1 ? {{16{!uns_q && rd_h[15]}}, rd_h} : bus.mem_rdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.lsu_reqValid) begin
        addr_q  <= bus.lsu_addr;
        wdata_q <= bus.lsu_wdata;
        size_q  <= bus.lsu_size;
        uns_q   <= bus.lsu_unsigned;
        wen_q   <= bus.lsu_wen;
        err_q   <= misalign;
      end
      // only load completions update the returned data
      if (state == WAIT && bus.mem_respValid && !wen_q) rdata_q <= rdata_ext;
    end
  always_comb begin
    bus.mem_reqValid  = state == REQ;
    bus.mem_wen       = wen_q;
    bus.mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    bus.mem_wdata     = size_q == 2'd0 ? {4{wdata_q[7:0]}} : size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    bus.mem_wstrb     = !wen_q ? 4'b0000 : size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                        size_q == 2'd1 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    bus.lsu_respValid = state == RESP;
    bus.lsu_err       = state == RESP && err_q;
    bus.lsu_rdata     = rdata_q;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus hand-written stall, reset and misalignment sequences.
module tb_lsu_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  lsu_ctrl_if #(.ADDR_W(32)) bus ();
  lsu_ctrl #(.ADDR_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] mrdata;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t vq[$];
  int tests = 0;
  int fails = 0;
  int hs = 0;
  int pulses = 0;
  always @(posedge clock) begin
    if (bus.mem_reqValid && bus.mem_reqReady) hs <= hs + 1;
    if (bus.lsu_respValid) pulses <= pulses + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic txn(input vec_t v, input int rdly, input int pdly);
    int h0, p0;
    h0 = hs;
    p0 = pulses;
    @(negedge clock);
    bus.lsu_reqValid = 1'b1;
    bus.lsu_wen = v.wen;
    bus.lsu_addr = v.addr;
    bus.lsu_wdata = v.wdata;
    bus.lsu_size = v.size;
    bus.lsu_unsigned = v.uns;
    @(negedge clock);
    chk("mem_reqValid", {31'b0, bus.mem_reqValid}, 32'd1);
    chk("mem_addr", bus.mem_addr, v.e_maddr);
    chk("mem_wen", {31'b0, bus.mem_wen}, {31'b0, v.wen});
    chk("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, v.e_wstrb});
    chk("mem_wdata", bus.mem_wdata, v.e_wdata);
    for (int i = 0; i < rdly; i++) begin
      bus.mem_respValid = 1'b1;
      bus.mem_rdata = 32'h5A5A_5A5A;
      @(negedge clock);
      chk("req_hold", {31'b0, bus.mem_reqValid}, 32'd1);
      chk("stall_no_resp", {31'b0, bus.lsu_respValid}, 32'd0);
    end
    bus.mem_respValid = 1'b0;
    bus.mem_reqReady = 1'b1;
    @(negedge clock);
    bus.mem_reqReady = 1'b0;
    chk("req_drop", {31'b0, bus.mem_reqValid}, 32'd0);
    for (int i = 0; i < pdly; i++) begin
      @(negedge clock);
      chk("early_resp", {31'b0, bus.lsu_respValid}, 32'd0);
    end
    bus.mem_respValid = 1'b1;
    bus.mem_rdata = v.mrdata;
    @(negedge clock);
    bus.mem_respValid = 1'b0;
    bus.mem_rdata = 32'hDEAD_0000;
    chk("lsu_respValid", {31'b0, bus.lsu_respValid}, 32'd1);
    chk("lsu_err", {31'b0, bus.lsu_err}, 32'd0);
    chk("lsu_rdata", bus.lsu_rdata, v.e_rdata);
    bus.lsu_reqValid = 1'b0;
    @(negedge clock);
    chk("resp_one_cycle", {31'b0, bus.lsu_respValid}, 32'd0);
    chk("bus_requests", hs - h0, 32'd1);
    chk("resp_pulses", pulses - p0, 32'd1);
    chk("rdata_held", bus.lsu_rdata, v.e_rdata);
  endtask
  initial begin
    int h0, p0;
    vec_t v;
    bus.lsu_reqValid = 1'b0;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = '0;
    bus.lsu_wdata = '0;
    bus.lsu_size = '0;
    bus.lsu_unsigned = 1'b0;
    bus.mem_reqReady = 1'b0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata = '0;
    //             wen   addr          wdata         sz    uns   mrdata        maddr         mwdata        strb   rdata
    vq.push_back('{1'b0, 32'h0000_1003, 32'h0000_0000, 2'd0, 1'b0, 32'h80FF_FFFF, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'hFFFF_FF80});
    vq.push_back('{1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'd1, 1'b0, 32'h1234_5678, 32'h0000_2000, 32'hABCD_ABCD, 4'hC, 32'hFFFF_FF80});
    vq.push_back('{1'b0, 32'h0000_2002, 32'h0000_0000, 2'd1, 1'b1, 32'h8001_7FFF, 32'h0000_2000, 32'h0000_0000, 4'h0, 32'h0000_8001});
    vq.push_back('{1'b0, 32'h0000_2000, 32'h0000_0000, 2'd1, 1'b0, 32'h1234_9876, 32'h0000_2000, 32'h0000_0000, 4'h0, 32'hFFFF_9876});
    vq.push_back('{1'b0, 32'h0000_0011, 32'h0000_0000, 2'd0, 1'b1, 32'h0000_C300, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0000_00C3});
    vq.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF});
    vq.push_back('{1'b1, 32'h0000_0051, 32'h1234_56AB, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0050, 32'hABAB_ABAB, 4'h2, 32'hDEAD_BEEF});
    vq.push_back('{1'b1, 32'h0000_0060, 32'hCAFE_F00D, 2'd3, 1'b0, 32'h0000_0000, 32'h0000_0060, 32'hCAFE_F00D, 4'hF, 32'hDEAD_BEEF});
    vq.push_back('{1'b0, 32'h0000_0002, 32'h0000_0000, 2'd0, 1'b0, 32'h007F_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_007F});
`ifndef LSU_MISALIGN_CHECK_EN
    vq.push_back('{1'b0, 32'h0000_0071, 32'h0000_0000, 2'd1, 1'b0, 32'h0000_8000, 32'h0000_0070, 32'h0000_0000, 4'h0, 32'hFFFF_8000});
`endif
    @(negedge clock);
    chk("rst_respValid", {31'b0, bus.lsu_respValid}, 32'd0);
    chk("rst_mem_reqValid", {31'b0, bus.mem_reqValid}, 32'd0);
    chk("rst_rdata", bus.lsu_rdata, 32'd0);
    chk("rst_err", {31'b0, bus.lsu_err}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    foreach (vq[i]) txn(vq[i], 0, 0);
    // ready held off 4 cycles with stray responses, then response 2 cycles after the handshake
    v = '{1'b0, 32'h0000_00A4, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0000_00A4, 32'h0, 4'h0, 32'h0BAD_F00D};
    txn(v, 4, 2);
    // reset while waiting for the memory response
    @(negedge clock);
    bus.lsu_reqValid = 1'b1;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = 32'h0000_0080;
    bus.lsu_size = 2'd2;
    @(negedge clock);
    bus.mem_reqReady = 1'b1;
    @(negedge clock);
    bus.mem_reqReady = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_reqValid", {31'b0, bus.mem_reqValid}, 32'd0);
    chk("arst_rdata", bus.lsu_rdata, 32'd0);
    chk("arst_respValid", {31'b0, bus.lsu_respValid}, 32'd0);
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    bus.lsu_reqValid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    p0 = pulses;
    bus.mem_respValid = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(negedge clock);
    bus.mem_respValid = 1'b0;
    @(negedge clock);
    chk("late_resp_ignored", pulses - p0, 32'd0);
    chk("late_rdata", bus.lsu_rdata, 32'd0);
    chk("late_no_req", {31'b0, bus.mem_reqValid}, 32'd0);
    txn(vq[0], 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    h0 = hs;
    @(negedge clock);
    bus.lsu_reqValid = 1'b1;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = 32'h0000_3001;
    bus.lsu_size = 2'd2;
    @(negedge clock);
    bus.lsu_reqValid = 1'b0;
    chk("mis_respValid", {31'b0, bus.lsu_respValid}, 32'd1);
    chk("mis_err", {31'b0, bus.lsu_err}, 32'd1);
    chk("mis_no_req", {31'b0, bus.mem_reqValid}, 32'd0);
    chk("mis_rdata", bus.lsu_rdata, 32'hFFFF_FF80);
    @(negedge clock);
    chk("mis_pulse", {31'b0, bus.lsu_respValid}, 32'd0);
    chk("mis_bus_idle", hs - h0, 32'd0);
`else
    h0 = hs;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port lsu_reqValid  input  1  core requests access (held high until response).
REQ-005 SHALL have port lsu_wen  input  1  1 store, 0 load.
REQ-006 SHALL have port lsu_addr  input  ADDR_W  byte address.
REQ-007 SHALL have port lsu_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port lsu_size  input  2  0 byte, 1 half, 2/3 word.
REQ-009 SHALL have port lsu_unsigned  input  1  zero-extend load data.
REQ-010 SHALL have port lsu_respValid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port lsu_rdata  output  32  extended load data.
REQ-012 SHALL have port lsu_err  output  1  misaligned-access error, qualified by lsu_respValid.
REQ-013 SHALL have ports mem_reqValid out 1, mem_reqReady in 1, mem_wen out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_wstrb out 4, mem_respValid in 1, mem_rdata in 32: word-wide memory bus.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, RESP.
REQ-015 IDLE: on lsu_reqValid SHALL capture addr, wdata, size, unsigned, wen and go to REQ; lsu_reqValid SHALL be ignored in every other state.
REQ-016 REQ: mem_reqValid SHALL be 1 with all mem_* outputs stable; on mem_reqReady=1 go to WAIT, else stay.
REQ-017 WAIT: on mem_respValid=1 SHALL register extended load data and go to RESP; mem_respValid outside WAIT SHALL be ignored.
REQ-018 RESP: lsu_respValid SHALL be 1 for exactly one cycle, then go to IDLE.
REQ-019 Minimum latency SHALL be 3 cycles from accepting edge to lsu_respValid (ready and response each same-cycle).
REQ-020 mem_addr SHALL equal {addr[ADDR_W-1:2],2'b00}; mem_wen SHALL equal captured wen.
REQ-021 Store strobe: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads SHALL drive mem_wstrb=0.
REQ-022 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-023 Load: byte from mem_rdata bits addr[1:0]*8, half from addr[1]*16, sign-extended unless unsigned; word passed through.
REQ-024 lsu_rdata SHALL hold its value until the next load completion; stores and errors SHALL leave it unchanged.

Reset
REQ-025 reset SHALL force IDLE, all outputs 0, captured registers and lsu_rdata 0, asynchronously.
REQ-026 reset mid-transaction SHALL abandon it; a late mem_respValid arriving in IDLE SHALL be ignored.

Configuration
REQ-027 Macro LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip the bus, go IDLE->RESP, and pulse lsu_respValid with lsu_err=1 (latency 1 cycle).
REQ-028 Macro undefined: lsu_err SHALL be tied 0; misaligned low bits ignored per REQ-021/023.

Verification
REQ-029 Load byte addr 0x1003, unsigned=0, mem_rdata 0x80FF_FFFF -> mem_addr 0x1000, wstrb 0, lsu_rdata 0xFFFF_FF80.
REQ-030 Store half addr 0x2002, wdata 0x0000_ABCD -> mem_wdata 0xABCD_ABCD, wstrb 4'b1100, lsu_rdata unchanged.
REQ-031 mem_reqReady low 4 cycles, mem_respValid 2 cycles later, lsu_reqValid held high -> exactly one bus request, one lsu_respValid pulse.
REQ-032 Reset asserted in WAIT, then mem_respValid pulse -> no lsu_respValid; next load completes normally.
REQ-033 With LSU_MISALIGN_CHECK_EN, load word addr 0x3001 -> mem_reqValid stays 0, lsu_respValid and lsu_err 1 one cycle after acceptance.
